// File: rtl/pc_pkg.sv
// Shared next-PC encodings and fixed addresses for the fetch PC generator.
package pc_pkg;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [31:0] EXC_VECTOR       = 32'h0000_4180;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// Combinational redirect target for one source: refetch, branch, jump or register jump.
module npc_calc import pc_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       sel_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [15:0]      imm16_i,
  input  logic [25:0]      index_i,
  input  logic [WIDTH-1:0] reg_i,
  output logic [WIDTH-1:0] target_o
);

  logic [WIDTH-1:0] base_plus4;
  logic [WIDTH-1:0] br_off;

  assign base_plus4 = base_i + WIDTH'(4);
  assign br_off     = {{(WIDTH-18){imm16_i[15]}}, imm16_i, 2'b00};

  always_comb begin
    unique case (sel_i)
      NPC_BR:  target_o = base_plus4 + br_off;
      NPC_J:   target_o = {base_plus4[WIDTH-1:28], index_i, 2'b00};
      NPC_JR:  target_o = reg_i;
      default: target_o = base_i;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator with prioritised redirects and a one-entry stall buffer.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHK_EN.
module pc_redirect_unit import pc_pkg::*; #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      NUM_SRC  = 2,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   stall_i,
  input  logic [NUM_SRC-1:0]     req_valid_i,
  input  logic [2*NUM_SRC-1:0]   req_sel_i,
  input  logic [WIDTH*NUM_SRC-1:0] req_base_i,
  input  logic [16*NUM_SRC-1:0]  req_imm16_i,
  input  logic [26*NUM_SRC-1:0]  req_index_i,
  input  logic [WIDTH*NUM_SRC-1:0] req_reg_i,
  output logic [WIDTH-1:0]       pc_o,
  output logic [WIDTH-1:0]       pc_plus4_o,
  output logic                   pending_o,
`ifdef PC_ALIGN_CHK_EN
  output logic                   align_exc_o,
`endif
  output logic                   redirect_taken_o
);

  logic [WIDTH-1:0] tgt [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    npc_calc #(.WIDTH(WIDTH)) u_npc_calc (
      .sel_i    (req_sel_i[2*g +: 2]),
      .base_i   (req_base_i[WIDTH*g +: WIDTH]),
      .imm16_i  (req_imm16_i[16*g +: 16]),
      .index_i  (req_index_i[26*g +: 26]),
      .reg_i    (req_reg_i[WIDTH*g +: WIDTH]),
      .target_o (tgt[g])
    );
  end

  logic             win_valid;
  logic [WIDTH-1:0] win_tgt;

  // Scan downwards so the lowest valid index is written last and wins.
  always_comb begin
    win_valid = 1'b0;
    win_tgt   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        win_valid = 1'b1;
        win_tgt   = tgt[i];
      end
    end
  end

  logic [WIDTH-1:0] pc_q, pc_d, ptgt_q, ptgt_d, load_tgt;
  logic             pending_q, pending_d, taken_q, taken_d, load;

  assign pc_plus4_o = pc_q + WIDTH'(4);

  always_comb begin
    pc_d      = pc_q;
    pending_d = pending_q;
    ptgt_d    = ptgt_q;
    load      = 1'b0;
    load_tgt  = win_tgt;
    if (stall_i) begin
      if (win_valid) begin
        pending_d = 1'b1;
        ptgt_d    = win_tgt;
      end
    end else if (win_valid) begin
      load      = 1'b1;
      pending_d = 1'b0;
    end else if (pending_q) begin
      load      = 1'b1;
      load_tgt  = ptgt_q;
      pending_d = 1'b0;
    end else begin
      pc_d = pc_plus4_o;
    end
    if (load) begin
      pc_d = load_tgt;
    end
    taken_d = load;
  end

`ifdef PC_ALIGN_CHK_EN
  logic align_q, align_d;
  logic [WIDTH-1:0] pc_chk_d;

  always_comb begin
    align_d  = load && (load_tgt[1:0] != 2'b00);
    pc_chk_d = align_d ? WIDTH'(EXC_VECTOR) : pc_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      align_q <= 1'b0;
    end else begin
      align_q <= align_d;
    end
  end

  assign align_exc_o = align_q;
`else
  logic [WIDTH-1:0] pc_chk_d;
  assign pc_chk_d = pc_d;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q      <= RESET_PC;
      pending_q <= 1'b0;
      ptgt_q    <= '0;
      taken_q   <= 1'b0;
    end else begin
      pc_q      <= pc_chk_d;
      pending_q <= pending_d;
      ptgt_q    <= ptgt_d;
      taken_q   <= taken_d;
    end
  end

  assign pc_o             = pc_q;
  assign pending_o        = pending_q;
  assign redirect_taken_o = taken_q;

endmodule
